// File: rtl/tagged_reg_file.sv
// tagged_reg_file: architectural register file with rename tags for a dual-issue dispatch unit.
//
// Each register holds a value, a busy bit and the tag of its pending producer. Two instruction
// buses (inst1 older, inst2 younger) rename destinations and read source operands. NUM_CDB result
// buses write values back by tag match. Operands are registered (1-cycle latency), computed from
// pre-update state, with forwarding from same-cycle result buses.
//
// Ports:
//   clk_i, rst_ni          clock; synchronous active-low reset
//   inst1_i/inst1_valid_i  older instruction {tag, op, src1, src2, dst}
//   inst2_i/inst2_valid_i  younger instruction, same format
//   cdb_i/cdb_valid_i      result buses, entry k = {tag, data}
//   opnd_data_o            {i2s2, i2s1, i1s2, i1s1} operand values
//   opnd_tag_o             producer tag for operands that are not ready
//   opnd_rdy_o             operand value valid
//   opnd_valid_o           registered {inst2_valid, inst1_valid}
//   reg_data_o/reg_busy_o  register values and pending-producer flags
//   err_o                  sticky scoreboard error
//
// Optional feature: define TRF_SCOREBOARD_CHK_EN to build the scoreboard check driving err_o.
// Without it err_o is tied to 0.

module tagged_reg_file #(
    parameter int unsigned      NUM_REGS = 4,
    parameter int unsigned      DATA_W   = 32,
    parameter int unsigned      FLD_W    = 8,
    parameter int unsigned      NUM_CDB  = 3,
    parameter logic [FLD_W-1:0] REG_BASE = 8'h10,
    parameter logic [FLD_W-1:0] OP_STORE = 8'h02
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic [5*FLD_W-1:0]                  inst1_i,
    input  logic                                inst1_valid_i,
    input  logic [5*FLD_W-1:0]                  inst2_i,
    input  logic                                inst2_valid_i,
    input  logic [NUM_CDB*(FLD_W+DATA_W)-1:0]   cdb_i,
    input  logic [NUM_CDB-1:0]                  cdb_valid_i,
    output logic [4*DATA_W-1:0]                 opnd_data_o,
    output logic [4*FLD_W-1:0]                  opnd_tag_o,
    output logic [3:0]                          opnd_rdy_o,
    output logic [1:0]                          opnd_valid_o,
    output logic [NUM_REGS*DATA_W-1:0]          reg_data_o,
    output logic [NUM_REGS-1:0]                 reg_busy_o,
    output logic                                err_o
);

    localparam int unsigned IdxW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int unsigned CdbW = FLD_W + DATA_W;

    function automatic logic in_range(input logic [FLD_W-1:0] f);
        return (int'(f) >= int'(REG_BASE)) && (int'(f) < int'(REG_BASE) + int'(NUM_REGS));
    endfunction

    function automatic logic [IdxW-1:0] reg_idx(input logic [FLD_W-1:0] f);
        return IdxW'(f - REG_BASE);
    endfunction

    logic [NUM_REGS-1:0][DATA_W-1:0] data_q, data_d;
    logic [NUM_REGS-1:0][FLD_W-1:0]  tag_q, tag_d;
    logic [NUM_REGS-1:0]             busy_q, busy_d;
    logic [3:0][DATA_W-1:0]          opnd_data_q, opnd_data_d;
    logic [3:0][FLD_W-1:0]           opnd_tag_q, opnd_tag_d;
    logic [3:0]                      opnd_rdy_q, opnd_rdy_d;
    logic [1:0]                      opnd_valid_q;

    // Instruction field decode
    logic [FLD_W-1:0]         i1_tag, i1_op, i1_dst, i2_tag, i2_op, i2_dst;
    logic [IdxW-1:0]          i1_idx, i2_idx;
    logic                     ren1, ren2;
    logic [3:0][FLD_W-1:0]    src;
    logic [3:0][IdxW-1:0]     src_idx;
    logic [3:0]               src_v;

    assign i1_tag = inst1_i[4*FLD_W +: FLD_W];
    assign i1_op  = inst1_i[3*FLD_W +: FLD_W];
    assign i1_dst = inst1_i[0 +: FLD_W];
    assign i2_tag = inst2_i[4*FLD_W +: FLD_W];
    assign i2_op  = inst2_i[3*FLD_W +: FLD_W];
    assign i2_dst = inst2_i[0 +: FLD_W];
    assign i1_idx = reg_idx(i1_dst);
    assign i2_idx = reg_idx(i2_dst);
    assign ren1   = inst1_valid_i && (i1_op != OP_STORE) && in_range(i1_dst);
    assign ren2   = inst2_valid_i && (i2_op != OP_STORE) && in_range(i2_dst);

    assign src[0] = inst1_i[2*FLD_W +: FLD_W];
    assign src[1] = inst1_i[1*FLD_W +: FLD_W];
    assign src[2] = inst2_i[2*FLD_W +: FLD_W];
    assign src[3] = inst2_i[1*FLD_W +: FLD_W];
    assign src_v  = {inst2_valid_i, inst2_valid_i, inst1_valid_i, inst1_valid_i};

    always_comb begin
        for (int o = 0; o < 4; o++) begin
            src_idx[o] = reg_idx(src[o]);
        end
    end

    // Result bus decode; tag 0 means "no producer" so it never matches
    logic [NUM_CDB-1:0][FLD_W-1:0]  cdb_tag;
    logic [NUM_CDB-1:0][DATA_W-1:0] cdb_data;
    logic [NUM_CDB-1:0]             cdb_live;

    always_comb begin
        for (int k = 0; k < int'(NUM_CDB); k++) begin
            cdb_tag[k]  = cdb_i[k*CdbW + DATA_W +: FLD_W];
            cdb_data[k] = cdb_i[k*CdbW +: DATA_W];
            cdb_live[k] = cdb_valid_i[k] && (cdb_tag[k] != '0);
        end
    end

    // Per-register writeback hit; iterate downwards so the lowest bus index wins
    logic [NUM_REGS-1:0]             wb_hit;
    logic [NUM_REGS-1:0][DATA_W-1:0] wb_data;

    always_comb begin
        for (int r = 0; r < int'(NUM_REGS); r++) begin
            wb_hit[r]  = 1'b0;
            wb_data[r] = '0;
            for (int k = int'(NUM_CDB) - 1; k >= 0; k--) begin
                if (busy_q[r] && cdb_live[k] && (cdb_tag[k] == tag_q[r])) begin
                    wb_hit[r]  = 1'b1;
                    wb_data[r] = cdb_data[k];
                end
            end
        end
    end

    // Operand read from pre-update state; the writeback hit doubles as the forward path
    always_comb begin
        for (int o = 0; o < 4; o++) begin
            opnd_rdy_d[o]  = 1'b0;
            opnd_tag_d[o]  = '0;
            opnd_data_d[o] = '0;
            if (!src_v[o]) begin
                // absent instruction: all fields stay 0
            end else if ((o >= 2) && ren1 && (src[o] == i1_dst)) begin
                // inst2 depends on inst1 of the same bundle
                opnd_tag_d[o] = i1_tag;
            end else if (!in_range(src[o])) begin
                opnd_rdy_d[o]  = 1'b1;
                opnd_data_d[o] = DATA_W'(src[o]);
            end else if (!busy_q[src_idx[o]]) begin
                opnd_rdy_d[o]  = 1'b1;
                opnd_data_d[o] = data_q[src_idx[o]];
            end else if (wb_hit[src_idx[o]]) begin
                opnd_rdy_d[o]  = 1'b1;
                opnd_data_d[o] = wb_data[src_idx[o]];
            end else begin
                opnd_tag_d[o] = tag_q[src_idx[o]];
            end
        end
    end

    // Register update: writeback, then inst1 rename, then inst2 rename (younger wins)
    always_comb begin
        data_d = data_q;
        tag_d  = tag_q;
        busy_d = busy_q;
        for (int r = 0; r < int'(NUM_REGS); r++) begin
            if (wb_hit[r]) begin
                data_d[r] = wb_data[r];
                busy_d[r] = 1'b0;
            end
            if (ren1 && (i1_idx == IdxW'(r))) begin
                tag_d[r]  = i1_tag;
                busy_d[r] = 1'b1;
            end
            if (ren2 && (i2_idx == IdxW'(r))) begin
                tag_d[r]  = i2_tag;
                busy_d[r] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            data_q       <= '0;
            tag_q        <= '0;
            busy_q       <= '0;
            opnd_data_q  <= '0;
            opnd_tag_q   <= '0;
            opnd_rdy_q   <= '0;
            opnd_valid_q <= '0;
        end else begin
            data_q       <= data_d;
            tag_q        <= tag_d;
            busy_q       <= busy_d;
            opnd_data_q  <= opnd_data_d;
            opnd_tag_q   <= opnd_tag_d;
            opnd_rdy_q   <= opnd_rdy_d;
            opnd_valid_q <= {inst2_valid_i, inst1_valid_i};
        end
    end

    assign opnd_data_o  = opnd_data_q;
    assign opnd_tag_o   = opnd_tag_q;
    assign opnd_rdy_o   = opnd_rdy_q;
    assign opnd_valid_o = opnd_valid_q;
    assign reg_data_o   = data_q;
    assign reg_busy_o   = busy_q;

`ifdef TRF_SCOREBOARD_CHK_EN
    // A live result tag must belong to some busy register, and no tag may appear twice
    logic [NUM_CDB-1:0] cdb_claimed;
    logic               err_q, err_d;

    always_comb begin
        cdb_claimed = '0;
        for (int k = 0; k < int'(NUM_CDB); k++) begin
            for (int r = 0; r < int'(NUM_REGS); r++) begin
                if (busy_q[r] && (tag_q[r] == cdb_tag[k])) begin
                    cdb_claimed[k] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        err_d = err_q;
        for (int k = 0; k < int'(NUM_CDB); k++) begin
            if (cdb_live[k] && !cdb_claimed[k]) begin
                err_d = 1'b1;
            end
            for (int j = k + 1; j < int'(NUM_CDB); j++) begin
                if (cdb_live[k] && cdb_live[j] && (cdb_tag[k] == cdb_tag[j])) begin
                    err_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_tagged_reg_file.sv
// tb_tagged_reg_file: self-checking bench for tagged_reg_file.
// Directed scenarios with literal expectations, then randomized traffic; every cycle the DUT
// outputs are compared with a behavioural model of the register file kept in plain arrays.

module tb_tagged_reg_file;

    localparam int unsigned NR = 4;
    localparam int unsigned DW = 32;
    localparam int unsigned FW = 8;
    localparam int unsigned NC = 3;
    localparam logic [7:0]  BASE  = 8'h10;
    localparam logic [7:0]  STORE = 8'h02;

    logic           clk;
    logic           rst_n;
    logic [39:0]    inst1, inst2;
    logic           inst1_valid, inst2_valid;
    logic [119:0]   cdb;
    logic [NC-1:0]  cdb_valid;
    logic [127:0]   opnd_data;
    logic [31:0]    opnd_tag;
    logic [3:0]     opnd_rdy;
    logic [1:0]     opnd_valid;
    logic [127:0]   reg_data;
    logic [3:0]     reg_busy;
    logic           err;

    tagged_reg_file #(
        .NUM_REGS (NR),
        .DATA_W   (DW),
        .FLD_W    (FW),
        .NUM_CDB  (NC),
        .REG_BASE (BASE),
        .OP_STORE (STORE)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .inst1_i       (inst1),
        .inst1_valid_i (inst1_valid),
        .inst2_i       (inst2),
        .inst2_valid_i (inst2_valid),
        .cdb_i         (cdb),
        .cdb_valid_i   (cdb_valid),
        .opnd_data_o   (opnd_data),
        .opnd_tag_o    (opnd_tag),
        .opnd_rdy_o    (opnd_rdy),
        .opnd_valid_o  (opnd_valid),
        .reg_data_o    (reg_data),
        .reg_busy_o    (reg_busy),
        .err_o         (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;

    // Next-cycle stimulus
    logic           n_rst;
    logic [39:0]    n_i1, n_i2;
    logic           n_v1, n_v2;
    logic [7:0]     n_ct [NC];
    logic [31:0]    n_cd [NC];
    logic [NC-1:0]  n_cv;

    // Model state and expected registered outputs
    logic [31:0]    m_data [NR];
    logic           m_busy [NR];
    logic [7:0]     m_tag  [NR];
    logic           m_err;
    logic [31:0]    e_data [4];
    logic [7:0]     e_tag  [4];
    logic           e_rdy  [4];
    logic [1:0]     e_valid;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic bit is_reg(input logic [7:0] f);
        return (int'(f) >= int'(BASE)) && (int'(f) < int'(BASE) + int'(NR));
    endfunction

    function automatic bit cdb_find(input logic [7:0] t, output int idx);
        idx = 0;
        for (int k = 0; k < int'(NC); k++) begin
            if (n_cv[k] && n_ct[k] != 8'h00 && n_ct[k] == t) begin
                idx = k;
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    task automatic model_apply();
        bit ren1, ren2, hit;
        int k, r;
        logic [39:0] in;
        logic [7:0] s;
        if (!n_rst) begin
            for (int i = 0; i < int'(NR); i++) begin
                m_data[i] = '0; m_busy[i] = 1'b0; m_tag[i] = '0;
            end
            for (int o = 0; o < 4; o++) begin
                e_data[o] = '0; e_tag[o] = '0; e_rdy[o] = 1'b0;
            end
            e_valid = 2'b00;
            m_err   = 1'b0;
            return;
        end
        ren1 = n_v1 && n_i1[31:24] != STORE && is_reg(n_i1[7:0]);
        ren2 = n_v2 && n_i2[31:24] != STORE && is_reg(n_i2[7:0]);
        for (int o = 0; o < 4; o++) begin
            in = (o < 2) ? n_i1 : n_i2;
            s  = (o % 2 == 0) ? in[23:16] : in[15:8];
            e_rdy[o] = 1'b0; e_tag[o] = '0; e_data[o] = '0;
            if (!((o < 2) ? n_v1 : n_v2)) begin
                // nothing presented
            end else if (o >= 2 && ren1 && s == n_i1[7:0]) begin
                e_tag[o] = n_i1[39:32];
            end else if (!is_reg(s)) begin
                e_rdy[o] = 1'b1; e_data[o] = 32'(s);
            end else begin
                r = int'(s) - int'(BASE);
                if (!m_busy[r]) begin
                    e_rdy[o] = 1'b1; e_data[o] = m_data[r];
                end else if (cdb_find(m_tag[r], k)) begin
                    e_rdy[o] = 1'b1; e_data[o] = n_cd[k];
                end else begin
                    e_tag[o] = m_tag[r];
                end
            end
        end
        e_valid = {n_v2, n_v1};
`ifdef TRF_SCOREBOARD_CHK_EN
        for (int a = 0; a < int'(NC); a++) begin
            if (n_cv[a] && n_ct[a] != 8'h00) begin
                hit = 1'b0;
                for (int i = 0; i < int'(NR); i++) begin
                    if (m_busy[i] && m_tag[i] == n_ct[a]) hit = 1'b1;
                end
                if (!hit) m_err = 1'b1;
                for (int b = a + 1; b < int'(NC); b++) begin
                    if (n_cv[b] && n_ct[b] == n_ct[a]) m_err = 1'b1;
                end
            end
        end
`else
        hit = 1'b0;
`endif
        for (int i = 0; i < int'(NR); i++) begin
            if (m_busy[i] && cdb_find(m_tag[i], k)) begin
                m_data[i] = n_cd[k]; m_busy[i] = 1'b0;
            end
        end
        if (ren1) begin
            r = int'(n_i1[7:0]) - int'(BASE); m_tag[r] = n_i1[39:32]; m_busy[r] = 1'b1;
        end
        if (ren2) begin
            r = int'(n_i2[7:0]) - int'(BASE); m_tag[r] = n_i2[39:32]; m_busy[r] = 1'b1;
        end
    endtask

    task automatic compare();
        logic [127:0] ed, mask, ereg;
        logic [31:0]  et;
        logic [3:0]   er, eb;
        for (int o = 0; o < 4; o++) begin
            ed[o*32 +: 32]   = e_data[o];
            et[o*8 +: 8]     = e_tag[o];
            er[o]            = e_rdy[o];
            mask[o*32 +: 32] = e_valid[o/2] ? 32'hFFFF_FFFF : 32'h0;
        end
        for (int i = 0; i < int'(NR); i++) begin
            ereg[i*32 +: 32] = m_data[i];
            eb[i]            = m_busy[i];
        end
        chk("opnd_valid", 128'(opnd_valid), 128'(e_valid));
        chk("opnd_rdy", 128'(opnd_rdy), 128'(er));
        chk("opnd_tag", 128'(opnd_tag), 128'(et));
        chk("opnd_data", opnd_data & mask, ed & mask);
        chk("reg_data", reg_data, ereg);
        chk("reg_busy", 128'(reg_busy), 128'(eb));
        chk("err", 128'(err), 128'(m_err));
    endtask

    task automatic step();
        @(negedge clk);
        rst_n       = n_rst;
        inst1       = n_i1;
        inst1_valid = n_v1;
        inst2       = n_i2;
        inst2_valid = n_v2;
        for (int k = 0; k < int'(NC); k++) begin
            cdb[k*40 +: 40] = {n_ct[k], n_cd[k]};
            cdb_valid[k]    = n_cv[k];
        end
        model_apply();
        @(posedge clk);
        #1;
        compare();
    endtask

    task automatic clr();
        n_rst = 1'b1; n_v1 = 1'b0; n_v2 = 1'b0; n_i1 = '0; n_i2 = '0; n_cv = '0;
        for (int k = 0; k < int'(NC); k++) begin
            n_ct[k] = '0; n_cd[k] = '0;
        end
    endtask

    function automatic logic [7:0] rand_fld();
        if ($urandom_range(0, 9) < 8) return 8'(BASE + 8'($urandom_range(0, 3)));
        return 8'($urandom);
    endfunction

    function automatic logic [39:0] rand_inst();
        logic [7:0] op;
        op = ($urandom_range(0, 3) == 0) ? STORE : 8'($urandom_range(3, 5));
        return {8'($urandom_range(0, 7)), op, rand_fld(), rand_fld(), rand_fld()};
    endfunction

    initial begin
        rst_n = 1'b0; inst1 = '0; inst2 = '0; inst1_valid = 1'b0; inst2_valid = 1'b0;
        cdb = '0; cdb_valid = '0;
        clr();

        // Reset held for two clocks with toggling inputs
        for (int c = 0; c < 2; c++) begin
            n_rst = 1'b0; n_v1 = 1'b1; n_v2 = 1'b1; n_i1 = rand_inst(); n_i2 = rand_inst();
            n_cv = '1;
            for (int k = 0; k < int'(NC); k++) begin
                n_ct[k] = 8'($urandom_range(1, 7)); n_cd[k] = $urandom;
            end
            step();
        end
        chk("rst_reg_data", reg_data, 128'h0);
        chk("rst_reg_busy", 128'(reg_busy), 128'h0);
        chk("rst_opnd", {opnd_data, opnd_tag, opnd_rdy, opnd_valid}, 128'h0);
        chk("rst_err", 128'(err), 128'h0);

        // Rename then writeback
        clr(); n_v1 = 1'b1; n_i1 = {8'h30, 8'h03, 8'h11, 8'h20, 8'h12}; step();
        chk("t2_busy2", 128'(reg_busy[2]), 128'h1);
        chk("t2_i1s2_imm", 128'(opnd_data[63:32]), 128'h20);
        clr(); n_v1 = 1'b1; n_i1 = {8'h60, 8'h02, 8'h12, 8'h00, 8'h00}; step();
        chk("t2_tag30", 128'({opnd_rdy[0], opnd_tag[7:0]}), 128'h030);
        clr(); n_cv[0] = 1'b1; n_ct[0] = 8'h30; n_cd[0] = 32'h3456_1234; step();
        chk("t2_reg2", 128'(reg_data[95:64]), 128'h3456_1234);
        chk("t2_busy2_clr", 128'(reg_busy[2]), 128'h0);

        // Dual rename of the same destination
        clr(); n_v1 = 1'b1; n_v2 = 1'b1;
        n_i1 = {8'h20, 8'h03, 8'h10, 8'h10, 8'h11}; n_i2 = {8'h40, 8'h01, 16'h0, 8'h11}; step();
        clr(); n_cv[1] = 1'b1; n_ct[1] = 8'h20; n_cd[1] = 32'hdead_beef; step();
        chk("t3_stale_tag", 128'({reg_busy[1], reg_data[63:32]}), 128'h1_0000_0000);
        clr(); n_cv[2] = 1'b1; n_ct[2] = 8'h40; n_cd[2] = 32'habcd_e23; n_cd[2] = 32'habcede23;
        step();
        chk("t3_reg1", 128'(reg_data[63:32]), 128'habcede23);

        // Intra-bundle dependency
        clr(); n_v1 = 1'b1; n_v2 = 1'b1;
        n_i1 = {8'h21, 8'h03, 8'h00, 8'h00, 8'h13}; n_i2 = {8'h41, 8'h03, 8'h13, 8'h00, 8'h00};
        step();
        chk("t4_dep", 128'({opnd_rdy[2], opnd_tag[23:16]}), 128'h021);

        // Forward plus simultaneous writeback and rename
        clr(); n_v1 = 1'b1; n_i1 = {8'h31, 8'h03, 8'h00, 8'h00, 8'h10}; step();
        clr(); n_v1 = 1'b1; n_v2 = 1'b1;
        n_i1 = {8'h51, 8'h03, 8'h10, 8'h00, 8'h00}; n_i2 = {8'h22, 8'h03, 8'h00, 8'h00, 8'h10};
        n_cv[0] = 1'b1; n_ct[0] = 8'h31; n_cd[0] = 32'h5; step();
        chk("t5_fwd", 128'({opnd_rdy[0], opnd_data[31:0]}), 128'h1_0000_0005);
        chk("t5_reg0", 128'({reg_busy[0], reg_data[31:0]}), 128'h1_0000_0005);
        clr(); n_v1 = 1'b1; n_i1 = {8'h52, 8'h02, 8'h10, 8'h00, 8'h00}; step();
        chk("t5_tag22", 128'({opnd_rdy[0], opnd_tag[7:0]}), 128'h022);

        // Store and non-register operand
        clr(); n_v1 = 1'b1; n_i1 = {8'h50, 8'h02, 8'h10, 8'h00, 8'h12}; step();
        chk("t6_no_rename", 128'(reg_busy[2]), 128'h0);
        chk("t6_i1s2", 128'({opnd_rdy[1], opnd_data[63:32]}), 128'h1_0000_0000);

        // Orphan result tag
        clr(); n_rst = 1'b0; step();
        chk("t7_err_rst", 128'(err), 128'h0);
        clr(); n_cv[0] = 1'b1; n_ct[0] = 8'h77; n_cd[0] = 32'h1; step();
`ifdef TRF_SCOREBOARD_CHK_EN
        chk("t7_err_set", 128'(err), 128'h1);
`else
        chk("t7_err_tied", 128'(err), 128'h0);
`endif

        // Randomized traffic, with occasional mid-run reset
        for (int c = 0; c < 2000; c++) begin
            n_rst = ($urandom_range(0, 99) >= 2);
            n_v1  = ($urandom_range(0, 3) != 0);
            n_v2  = ($urandom_range(0, 3) != 0);
            n_i1  = rand_inst();
            n_i2  = rand_inst();
            for (int k = 0; k < int'(NC); k++) begin
                n_cv[k] = ($urandom_range(0, 2) == 0);
                n_ct[k] = ($urandom_range(0, 1) == 0) ? m_tag[$urandom_range(0, NR - 1)]
                                                      : 8'($urandom_range(0, 7));
                n_cd[k] = $urandom;
            end
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tagged_reg_file.md
Name: tagged_reg_file

Overview:
- Parametrised architectural register file with rename tags for the dual-issue dispatch unit.
- Each register holds a value, a busy bit and the reservation-station tag of its pending producer.
- Two instruction buses rename destinations and read source operands. NUM_CDB result buses write back values by tag matching.
- Operands go to the reservation stations with forwarding from same-cycle result buses.

Parameters:
- NUM_REGS, 4, number of architectural registers.
- DATA_W, 32, register/result data width.
- FLD_W, 8, width of every instruction field and tag.
- NUM_CDB, 3, number of result buses (load, mult, add).
- REG_BASE, 8'h10, ID of register 0; IDs REG_BASE..REG_BASE+NUM_REGS-1 are registers.
- OP_STORE, 8'h02, opcode with no destination write.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; synchronous, active-low
- inst1  in  5*FLD_W  {tag, op, src1, src2, dst}; older instruction
- inst1_valid  in  1  inst1 present
- inst2  in  5*FLD_W  same format; younger instruction
- inst2_valid  in  1  inst2 present
- cdb  in  NUM_CDB*(FLD_W+DATA_W)  flat array, entry k = {tag, data}
- cdb_valid  in  NUM_CDB  per-bus valid
- opnd_data  out  4*DATA_W  {i2s2, i2s1, i1s2, i1s1} operand values
- opnd_tag  out  4*FLD_W  producer tag when operand not ready
- opnd_rdy  out  4  operand value valid
- opnd_valid  out  2  registered inst2_valid/inst1_valid
- reg_data  out  NUM_REGS*DATA_W  register values
- reg_busy  out  NUM_REGS  pending-producer flags
- err  out  1  scoreboard error (see Optional Feature)

Behaviour:
- Reset (rst_n=0 at posedge): all register data, tags and busy bits go to 0. All outputs go to 0. Reset mid-operation discards pending renames; later CDB traffic for those tags has no effect.
- Tag 0 means "no producer". A CDB entry with tag 0 is ignored even when valid.
- Rename condition: valid, op != OP_STORE, and dst within register range. An out-of-range dst is ignored.
- Per-register update order in one cycle:
  - (1) Writeback: if busy and any valid CDB tag equals the register tag, data <= that CDB data and busy <= 0. If several CDBs match, the lowest index wins.
  - (2) inst1 rename: tag <= inst1.tag, busy <= 1.
  - (3) inst2 rename overrides inst1. The younger instruction owns the register.
  - Writeback and rename together: data is written, and the new tag and busy=1 are kept.
- Operand read: registered, 1-cycle latency, computed from pre-update state.
  - Source out of register range: rdy=1, data = zero-extended field, tag=0.
  - Register not busy: rdy=1, data = register value.
  - Register busy and a same-cycle valid CDB matches its tag: rdy=1, data = CDB data (forward).
  - Otherwise: rdy=0, tag = register tag, data=0.
  - inst2 source equal to a renamed inst1 dst: rdy=0, tag=inst1.tag. This intra-bundle dependency overrides all rules above.
- With an instruction not valid, its opnd_rdy and opnd_tag fields are 0.
- reg_data and reg_busy reflect state after the edge.

Optional Feature:
- Macro TRF_SCOREBOARD_CHK_EN.
- Defined: err is a registered sticky flag, cleared only by reset. It sets when:
  - a valid nonzero CDB tag matches no busy register, or
  - two valid CDB entries carry the same nonzero tag in one cycle.
- Undefined: err is tied 0 and no check logic is built.

Test Plan:
- Reset: hold rst_n=0 for 2 clocks with inputs toggling -> reg_data=0, reg_busy=0, all opnd_* = 0, err=0.
- Rename then writeback: inst1={8'h30,8'h03,8'h11,8'h20,8'h12} valid. Next cycle reg_busy[2]=1 with tag 8'h30. Then cdb entry {8'h30,32'h34561234} -> reg2=32'h34561234, busy[2]=0.
- Dual rename of the same dst: inst1={8'h20,8'h03,8'h10,8'h10,8'h11}, inst2={8'h40,8'h01,16'h0,8'h11} -> R1 tag 8'h40. A later cdb {8'h20,...} leaves R1 unchanged; cdb {8'h40,32'habcede23} -> reg1=32'habcede23.
- Intra-bundle dependency: inst1 dst R3 tag 8'h21, inst2 src1=8'h13 -> opnd_rdy[2]=0, opnd_tag i2s1=8'h21.
- Forward and simultaneous writeback+rename:
  - R0 busy tag 8'h31; inst1 reads R0 while cdb {8'h31,32'h5} is valid -> opnd_rdy[0]=1, data 5.
  - Same cycle, inst2 renames R0 with tag 8'h22 -> reg0=5, busy[0]=1, tag 8'h22.
- Non-register operands and STORE:
  - inst1={8'h50,8'h02,8'h10,8'h00,8'h12} -> R2 not renamed; opnd i1s2 rdy=1, data 0.
  - With TRF_SCOREBOARD_CHK_EN defined, cdb tag 8'h77 valid -> err=1 next cycle.
